// File: rtl/hba_master_seq.sv
// hba_master_seq: programmable HBA master command sequencer.
// Executes WRITE/READ/POLL/DELAY/JUMP/END instructions from a small internal
// program RAM and drives the app-side request interface of an hba_master.
module hba_master_seq #(
    parameter int unsigned DBUS_WIDTH        = 8,
    parameter int unsigned PERIPH_ADDR_WIDTH = 4,
    parameter int unsigned REG_ADDR_WIDTH    = 8,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned PC_WIDTH          = 4,
    parameter int unsigned DELAY_UNIT        = 1000,
    parameter int unsigned POLL_MAX          = 0,
    parameter int unsigned INSTR_WIDTH       = 3 + PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH + DBUS_WIDTH
) (
    input  logic                         hba_clk,
    input  logic                         hba_reset,
    input  logic                         seq_en,
    input  logic                         prog_we,
    input  logic [PC_WIDTH-1:0]          prog_addr,
    input  logic [INSTR_WIDTH-1:0]       prog_data,
    output logic [PERIPH_ADDR_WIDTH-1:0] app_core_addr,
    output logic [REG_ADDR_WIDTH-1:0]    app_reg_addr,
    output logic [DBUS_WIDTH-1:0]        app_data_in,
    output logic                         app_rnw,
    output logic                         app_en_strobe,
    input  logic [DBUS_WIDTH-1:0]        app_data_out,
    input  logic                         app_valid_out,
    output logic                         seq_busy,
    output logic                         seq_done,
    output logic                         seq_err,
    output logic [PC_WIDTH-1:0]          seq_pc,
    output logic [DBUS_WIDTH-1:0]        seq_rd_data
);

    // Wide enough to hold data * DELAY_UNIT for any data value.
    localparam int unsigned DlyW = DBUS_WIDTH + $clog2(DELAY_UNIT + 1);

    localparam logic [2:0] OpEnd   = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpRead  = 3'd2;
    localparam logic [2:0] OpPoll  = 3'd3;
    localparam logic [2:0] OpDelay = 3'd4;
    localparam logic [2:0] OpJump  = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StXfer,
        StDelay,
        StDone,
        StError
    } state_e;

    state_e                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]         instr_q, instr_d;
    logic [PERIPH_ADDR_WIDTH-1:0]   core_q, core_d;
    logic [REG_ADDR_WIDTH-1:0]      reg_q, reg_d;
    logic [DBUS_WIDTH-1:0]          wdata_q, wdata_d;
    logic                           rnw_q, rnw_d;
    logic                           strobe_q, strobe_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic [DBUS_WIDTH-1:0]          rd_data_q, rd_data_d;
    logic [31:0]                    poll_cnt_q, poll_cnt_d;
    logic [DlyW-1:0]                delay_cnt_q, delay_cnt_d;
    logic                           abort_q, abort_d;
    logic                           seq_en_q;

    logic [INSTR_WIDTH-1:0]         prog_mem [DEPTH];

    logic [2:0]                     instr_op;
    logic [PERIPH_ADDR_WIDTH-1:0]   instr_core;
    logic [REG_ADDR_WIDTH-1:0]      instr_reg;
    logic [DBUS_WIDTH-1:0]          instr_data;
    logic                           seq_rise;
    logic                           seq_fall;
    logic                           abort_pend;
    logic [PC_WIDTH-1:0]            pc_inc;
    logic [31:0]                    poll_cnt_inc;
    logic                           poll_limit;

    assign instr_op   = instr_q[INSTR_WIDTH-1 -: 3];
    assign instr_core = instr_q[INSTR_WIDTH-4 -: PERIPH_ADDR_WIDTH];
    assign instr_reg  = instr_q[DBUS_WIDTH +: REG_ADDR_WIDTH];
    assign instr_data = instr_q[DBUS_WIDTH-1:0];

    assign seq_rise     = seq_en & ~seq_en_q;
    assign seq_fall     = ~seq_en & seq_en_q;
    // An abort seen during XFER is remembered until the transfer completes.
    assign abort_pend   = abort_q | seq_fall;
    assign pc_inc       = pc_q + PC_WIDTH'(1);
    assign poll_cnt_inc = poll_cnt_q + 32'd1;
    assign poll_limit   = (POLL_MAX != 0) && (poll_cnt_inc == POLL_MAX);

    // Program RAM: written only while the sequencer is not running; never cleared.
    always_ff @(posedge hba_clk) begin
        if (prog_we && !busy_q) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            instr_q     <= '0;
            core_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rnw_q       <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            poll_cnt_q  <= '0;
            delay_cnt_q <= '0;
            abort_q     <= 1'b0;
            seq_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            core_q      <= core_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rnw_q       <= rnw_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            poll_cnt_q  <= poll_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            abort_q     <= abort_d;
            seq_en_q    <= seq_en;
        end
    end

    // Next-state logic: fetch/decode/execute sequencing and abort handling.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        core_d      = core_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rnw_d       = rnw_q;
        strobe_d    = strobe_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        poll_cnt_d  = poll_cnt_q;
        delay_cnt_d = delay_cnt_q;
        abort_d     = abort_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (seq_rise) begin
                    pc_d       = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    abort_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StFetch;
                end
            end

            StFetch: begin
                if (abort_pend) begin
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    instr_d = prog_mem[pc_q];
                    state_d = StDecode;
                end
            end

            StDecode: begin
                if (abort_pend) begin
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    unique case (instr_op)
                        OpEnd: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StDone;
                        end
                        OpWrite, OpRead, OpPoll: begin
                            core_d   = instr_core;
                            reg_d    = instr_reg;
                            wdata_d  = instr_data;
                            rnw_d    = (instr_op != OpWrite);
                            strobe_d = 1'b1;
                            state_d  = StXfer;
                        end
                        OpDelay: begin
                            if (instr_data == '0) begin
                                pc_d    = pc_inc;
                                state_d = StFetch;
                            end else begin
                                delay_cnt_d = DlyW'(instr_data) * DlyW'(DELAY_UNIT) - DlyW'(1);
                                state_d     = StDelay;
                            end
                        end
                        OpJump: begin
                            pc_d    = instr_data[PC_WIDTH-1:0];
                            state_d = StFetch;
                        end
                        default: begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StError;
                        end
                    endcase
                end
            end

            StXfer: begin
                abort_d = abort_pend;
                if (app_valid_out) begin
                    strobe_d = 1'b0;
                    if (instr_op != OpWrite) begin
                        rd_data_d = app_data_out;
                    end
                    if (instr_op == OpPoll && app_data_out != instr_data) begin
                        poll_cnt_d = poll_cnt_inc;
                        if (abort_pend) begin
                            busy_d  = 1'b0;
                            abort_d = 1'b0;
                            state_d = StIdle;
                        end else if (poll_limit) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StError;
                        end else begin
                            state_d = StFetch;
                        end
                    end else begin
                        poll_cnt_d = '0;
                        pc_d       = pc_inc;
                        if (abort_pend) begin
                            busy_d  = 1'b0;
                            abort_d = 1'b0;
                            state_d = StIdle;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
            end

            StDelay: begin
                if (abort_pend) begin
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                    state_d = StIdle;
                end else if (delay_cnt_q == '0) begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end else begin
                    delay_cnt_d = delay_cnt_q - DlyW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign app_core_addr = core_q;
    assign app_reg_addr  = reg_q;
    assign app_data_in   = wdata_q;
    assign app_rnw       = rnw_q;
    assign app_en_strobe = strobe_q;
    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign seq_err       = err_q;
    assign seq_pc        = pc_q;
    assign seq_rd_data   = rd_data_q;

endmodule

// File: tb/tb_hba_master_seq.sv
// Self-checking bench for hba_master_seq: reference model + scoreboard queues.
module tb_hba_master_seq;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned RW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;
    localparam int unsigned DU    = 4;
    localparam int unsigned IW    = 3 + AW + RW + DW;

    typedef struct packed {
        logic [3:0] core;
        logic [7:0] rg;
        logic [7:0] data;
        logic       rnw;
    } xfer_t;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [3:0]  pc;
        logic [7:0]  rd;
        logic [31:0] cycles;
    } end_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          seq_en, seq_en_pm;
    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [AW-1:0] core, core_pm;
    logic [RW-1:0] rg, rg_pm;
    logic [DW-1:0] wdat, wdat_pm;
    logic          rnw, rnw_pm;
    logic          strobe, strobe_pm;
    logic [DW-1:0] rdata, rdata_pm;
    logic          valid, valid_pm;
    logic          busy, busy_pm, done, done_pm, err, err_pm;
    logic [PW-1:0] pc, pc_pm;
    logic [DW-1:0] rd, rd_pm;

    xfer_t      exp_xfer_q[$];
    end_t       exp_end_q[$];
    int         lat_q[$];
    logic [7:0] rsp_q[$];
    logic [7:0] forced_rd[$];
    logic [IW-1:0] shadow [DEPTH];
    logic [7:0] model_rd;
    int         checks = 0;
    int         errors = 0;
    int         pm_reads = 0;

    always #5 clk = ~clk;

    hba_master_seq #(.DELAY_UNIT(DU), .POLL_MAX(0)) dut (
        .hba_clk(clk), .hba_reset(rst), .seq_en(seq_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .app_core_addr(core),
        .app_reg_addr(rg), .app_data_in(wdat), .app_rnw(rnw), .app_en_strobe(strobe),
        .app_data_out(rdata), .app_valid_out(valid), .seq_busy(busy), .seq_done(done),
        .seq_err(err), .seq_pc(pc), .seq_rd_data(rd)
    );

    hba_master_seq #(.DELAY_UNIT(DU), .POLL_MAX(2)) dut_pm (
        .hba_clk(clk), .hba_reset(rst), .seq_en(seq_en_pm), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .app_core_addr(core_pm),
        .app_reg_addr(rg_pm), .app_data_in(wdat_pm), .app_rnw(rnw_pm),
        .app_en_strobe(strobe_pm), .app_data_out(rdata_pm), .app_valid_out(valid_pm),
        .seq_busy(busy_pm), .seq_done(done_pm), .seq_err(err_pm), .seq_pc(pc_pm),
        .seq_rd_data(rd_pm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int c, input int r, input int d);
        return {op[2:0], c[3:0], r[7:0], d[7:0]};
    endfunction

    task automatic load(input int idx, input logic [IW-1:0] w);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = idx[3:0];
        prog_data = w;
        shadow[idx] = w;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Reference model: walks the program and predicts transfers, bus responses,
    // final status and the number of cycles seq_busy stays high.
    task automatic model_run();
        int pc_m = 0;
        int cyc = 0;
        int steps = 0;
        int lat;
        int tries;
        logic [IW-1:0] w;
        logic [2:0] op;
        logic [7:0] d;
        logic [7:0] v;
        logic stop = 1'b0;
        while (!stop && steps < 64) begin
            steps++;
            w  = shadow[pc_m];
            op = w[22:20];
            d  = w[7:0];
            case (op)
                3'd0: begin
                    exp_end_q.push_back('{1'b1, 1'b0, 4'(pc_m), model_rd, 32'(cyc + 2)});
                    stop = 1'b1;
                end
                3'd1, 3'd2: begin
                    lat = $urandom_range(1, 4);
                    if (op == 3'd2 && forced_rd.size() > 0) v = forced_rd.pop_front();
                    else v = 8'($urandom);
                    exp_xfer_q.push_back('{w[19:16], w[15:8], d, op == 3'd2});
                    lat_q.push_back(lat);
                    rsp_q.push_back(v);
                    if (op == 3'd2) model_rd = v;
                    cyc += 2 + lat;
                    pc_m = (pc_m + 1) % DEPTH;
                end
                3'd3: begin
                    tries = 0;
                    do begin
                        lat = $urandom_range(1, 4);
                        if (forced_rd.size() > 0) v = forced_rd.pop_front();
                        else if (tries >= 3) v = d;
                        else if ($urandom_range(0, 1) == 1) v = d;
                        else v = 8'($urandom);
                        exp_xfer_q.push_back('{w[19:16], w[15:8], d, 1'b1});
                        lat_q.push_back(lat);
                        rsp_q.push_back(v);
                        model_rd = v;
                        cyc += 2 + lat;
                        tries++;
                    end while (v != d);
                    pc_m = (pc_m + 1) % DEPTH;
                end
                3'd4: begin
                    cyc += 2 + int'(d) * DU;
                    pc_m = (pc_m + 1) % DEPTH;
                end
                3'd5: begin
                    cyc += 2;
                    pc_m = int'(d) % DEPTH;
                end
                default: begin
                    exp_end_q.push_back('{1'b0, 1'b1, 4'(pc_m), model_rd, 32'(cyc + 2)});
                    stop = 1'b1;
                end
            endcase
        end
    endtask

    task automatic wait_end(input int limit);
        int n = 0;
        while (exp_end_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_end_q.size() != 0) begin
            fail_now("run_timeout");
            exp_end_q.delete();
            exp_xfer_q.delete();
        end
    endtask

    task automatic run_prog();
        model_run();
        @(negedge clk);
        seq_en = 1'b1;
        wait_end(3000);
        @(negedge clk);
        seq_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!strobe && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!strobe) fail_now("strobe_timeout");
    endtask

    // Start, then drop seq_en during the first transfer of [WRITE; JUMP 0].
    task automatic abort_run();
        exp_xfer_q.push_back('{4'd7, 8'd2, 8'h44, 1'b0});
        lat_q.push_back(3);
        rsp_q.push_back(8'h00);
        exp_end_q.push_back('{1'b0, 1'b0, 4'd1, model_rd, 32'd5});
        @(negedge clk);
        seq_en = 1'b1;
        wait_strobe();
        seq_en = 1'b0;
        wait_end(200);
        repeat (10) @(negedge clk);
        chk("abort_no_restrobe", strobe, 1'b0);
        chk("abort_busy", busy, 1'b0);
    endtask

    // Bus responder for the main DUT: answers each request after a model-chosen latency.
    initial begin
        int l;
        logic [7:0] d;
        valid = 1'b0;
        rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && strobe && !valid) begin
                l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                d = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
                repeat (l - 1) begin
                    @(posedge clk);
                    #1;
                end
                valid = 1'b1;
                rdata = d;
                @(posedge clk);
                #1;
                valid = 1'b0;
            end
        end
    end

    // Responder for the POLL_MAX DUT: one-cycle latency, always returns 0.
    initial begin
        valid_pm = 1'b0;
        rdata_pm = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && strobe_pm && !valid_pm) begin
                pm_reads++;
                valid_pm = 1'b1;
                @(posedge clk);
                #1;
                valid_pm = 1'b0;
            end
        end
    end

    // Monitor: pops expected transfers on each request and expected status on busy fall.
    initial begin
        logic  s_prev = 1'b0;
        logic  b_prev = 1'b0;
        logic  v_prev = 1'b0;
        int    gap = 99;
        int    bcnt = 0;
        xfer_t cur = '0;
        end_t  e;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_prev = 1'b0;
                b_prev = 1'b0;
                v_prev = 1'b0;
                gap    = 99;
            end else begin
                if (v_prev) chk("strobe_drop_after_valid", strobe, 1'b0);
                if (strobe && !s_prev) begin
                    chk("strobe_low_gap_ge2", gap >= 2, 1'b1);
                    if (exp_xfer_q.size() == 0) begin
                        fail_now("unexpected_xfer");
                    end else begin
                        cur = exp_xfer_q.pop_front();
                        chk("xfer_core", core, cur.core);
                        chk("xfer_reg", rg, cur.rg);
                        chk("xfer_wdata", wdat, cur.data);
                        chk("xfer_rnw", rnw, cur.rnw);
                    end
                end else if (strobe) begin
                    chk("xfer_stable", {core, rg, wdat, rnw}, cur);
                end
                gap = strobe ? 0 : gap + 1;
                if (busy) bcnt = b_prev ? bcnt + 1 : 1;
                if (!busy && b_prev) begin
                    if (exp_end_q.size() == 0) begin
                        fail_now("unexpected_end");
                    end else begin
                        e = exp_end_q.pop_front();
                        chk("end_done", done, e.done);
                        chk("end_err", err, e.err);
                        chk("end_pc", pc, e.pc);
                        chk("end_rd_data", rd, e.rd);
                        chk("end_busy_cycles", bcnt, e.cycles);
                        chk("end_xfers_drained", exp_xfer_q.size(), 0);
                    end
                end
                s_prev = strobe;
                b_prev = busy;
                v_prev = valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog_expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int r;
        int tgt;
        rst       = 1'b1;
        seq_en    = 1'b0;
        seq_en_pm = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        model_rd  = 8'h00;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobe", strobe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_rd_data", rd, 8'h00);
        chk("rst_app_fields", {core, rg, wdat, rnw}, 21'd0);
        rst = 1'b0;

        // Single write then END.
        load(0, mk(1, 1, 0, 8'h01));
        load(1, mk(0, 0, 0, 0));
        run_prog();

        // Read returning 0xA5.
        forced_rd.push_back(8'hA5);
        load(0, mk(2, 2, 3, 0));
        load(1, mk(0, 0, 0, 0));
        run_prog();
        chk("read_rd_data", rd, 8'hA5);

        // Poll that matches on the third read.
        forced_rd.push_back(8'h00);
        forced_rd.push_back(8'h03);
        forced_rd.push_back(8'h07);
        load(0, mk(3, 4, 1, 8'h07));
        load(1, mk(0, 0, 0, 0));
        run_prog();

        // DELAY 3 (12 cycles) and DELAY 0 (none).
        load(0, mk(4, 0, 0, 3));
        run_prog();
        load(0, mk(4, 0, 0, 0));
        run_prog();

        // Abort mid-transfer, twice: second start must begin again at pc 0.
        load(0, mk(1, 7, 2, 8'h44));
        load(1, mk(5, 0, 0, 8'h00));
        abort_run();
        abort_run();

        // Illegal opcode at pc 2.
        load(0, mk(1, 1, 1, 8'h11));
        load(1, mk(1, 2, 2, 8'h22));
        load(2, mk(6, 0, 0, 0));
        load(3, mk(0, 0, 0, 0));
        run_prog();
        chk("illegal_err", err, 1'b1);
        chk("illegal_pc", pc, 4'd2);

        // Program writes while busy are dropped; shadow keeps the original.
        load(0, mk(4, 0, 0, 3));
        load(1, mk(1, 5, 6, 8'h5A));
        load(2, mk(0, 0, 0, 0));
        model_run();
        @(negedge clk);
        seq_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_during_prog_we", busy, 1'b1);
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = mk(1, 9, 9, 8'h99);
        @(negedge clk);
        prog_we = 1'b0;
        wait_end(500);
        @(negedge clk);
        seq_en = 1'b0;
        repeat (2) @(negedge clk);

        // POLL_MAX = 2 instance: never-matching poll errors after two reads.
        load(0, mk(3, 4, 1, 8'h07));
        load(1, mk(0, 0, 0, 0));
        pm_reads = 0;
        @(negedge clk);
        seq_en_pm = 1'b1;
        for (int n = 0; n < 200 && !err_pm && !done_pm; n++) @(negedge clk);
        chk("pm_err", err_pm, 1'b1);
        chk("pm_done", done_pm, 1'b0);
        chk("pm_busy", busy_pm, 1'b0);
        chk("pm_reads", pm_reads, 2);
        chk("pm_pc", pc_pm, 4'd0);
        chk("pm_rd_data", rd_pm, 8'h00);
        chk("pm_fields", {core_pm, rg_pm, wdat_pm, rnw_pm}, {4'd4, 8'd1, 8'h07, 1'b1});
        seq_en_pm = 1'b0;
        repeat (2) @(negedge clk);

        // Randomised programs with forward-only jumps.
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(2, 8);
            for (int i = 0; i < len - 1; i++) begin
                r = $urandom_range(0, 19);
                if (r < 5) load(i, mk(1, $urandom, $urandom, $urandom));
                else if (r < 9) load(i, mk(2, $urandom, $urandom, $urandom));
                else if (r < 13) load(i, mk(3, $urandom, $urandom, $urandom));
                else if (r < 16) load(i, mk(4, $urandom, $urandom, $urandom_range(0, 3)));
                else if (r < 19) begin
                    tgt = $urandom_range(i + 1, len - 1);
                    load(i, mk(5, $urandom, $urandom, ($urandom_range(0, 15) << 4) | tgt));
                end else load(i, mk($urandom_range(6, 7), 0, 0, 0));
            end
            load(len - 1, mk(0, $urandom, $urandom, $urandom));
            run_prog();
        end

        // Reset during a transfer clears every output on the next cycle.
        load(0, mk(1, 3, 9, 8'h33));
        load(1, mk(0, 0, 0, 0));
        exp_xfer_q.push_back('{4'd3, 8'd9, 8'h33, 1'b0});
        lat_q.push_back(6);
        rsp_q.push_back(8'h00);
        @(negedge clk);
        seq_en = 1'b1;
        wait_strobe();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_strobe", strobe, 1'b0);
        chk("rstx_busy", busy, 1'b0);
        chk("rstx_status", {done, err}, 2'b00);
        chk("rstx_pc", pc, 4'd0);
        chk("rstx_rd_data", rd, 8'h00);
        chk("rstx_app_fields", {core, rg, wdat, rnw}, 21'd0);
        rst      = 1'b0;
        seq_en   = 1'b0;
        model_rd = 8'h00;
        repeat (12) @(negedge clk);
        lat_q.delete();
        rsp_q.delete();

        // Recovery after reset: RAM contents survive.
        shadow[0] = mk(1, 3, 9, 8'h33);
        shadow[1] = mk(0, 0, 0, 0);
        run_prog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
